lookupflow_arbiter: RTL and testbench

- Shares one lookupflow flow-table engine between NPORT ingress requesters, which are the per-port packet parsers.
- Round-robin grant; one lookup in flight at a time.
- Drives the engine's req/data; routes the engine's ack/err/fwd_port back to the granted requester.
- Adds a response timeout, so a missing engine ack cannot hang a port.

---
 rtl/lookupflow_pkg.sv | 39 +++
 rtl/lookupflow_arbiter_rr.sv | 30 +++
 rtl/lookupflow_arbiter.sv | 128 ++++++++++++
 tb/tb_lookupflow_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lookupflow_pkg.sv
// Shared constants, FSM state encoding and flow-key layout for the lookupflow
// arbiter and its users.
package lookupflow_pkg;

    localparam int LOOKUP_W = 116;

    // Flow-key field layout, LSB positions and widths.
    localparam int KEY_INGRESS_LSB = 112;
    localparam int KEY_INGRESS_W   = 4;
    localparam int KEY_SRCMAC_LSB  = 64;
    localparam int KEY_SRCMAC_W    = 48;
    localparam int KEY_DSTIP_LSB   = 32;
    localparam int KEY_DSTIP_W     = 32;
    localparam int KEY_SRCIP_LSB   = 0;
    localparam int KEY_SRCIP_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [LOOKUP_W-1:0] make_key(
        input logic [KEY_INGRESS_W-1:0] ingress,
        input logic [KEY_SRCMAC_W-1:0]  srcmac,
        input logic [KEY_DSTIP_W-1:0]   dstip,
        input logic [KEY_SRCIP_W-1:0]   srcip
    );
        logic [LOOKUP_W-1:0] key;
        key = '0;
        key[KEY_INGRESS_LSB +: KEY_INGRESS_W] = ingress;
        key[KEY_SRCMAC_LSB  +: KEY_SRCMAC_W]  = srcmac;
        key[KEY_DSTIP_LSB   +: KEY_DSTIP_W]   = dstip;
        key[KEY_SRCIP_LSB   +: KEY_SRCIP_W]   = srcip;
        return key;
    endfunction

endpackage

// File: rtl/lookupflow_arbiter_rr.sv
// Combinational round-robin pick: first requesting index at or after the
// pointer, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        logic [IW-1:0] k;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = '0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i >= N) ? IW'(int'(ptr_i) + i - N) : IW'(int'(ptr_i) + i);
            if (!valid_o && req_i[k]) begin
                valid_o    = 1'b1;
                idx_o      = k;
                grant_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lookupflow_arbiter.sv
// Shares one lookupflow engine between NPORT parsers: round-robin grant, one
// lookup in flight, response timeout, one-cycle hold-off after each answer.
module lookupflow_arbiter #(
    parameter int NPORT    = 4,
    parameter int LOOKUP_W = lookupflow_pkg::LOOKUP_W,
    parameter int TIMEOUT  = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NPORT-1:0]          port_req,
    input  logic [NPORT*LOOKUP_W-1:0] port_data,
    output logic [NPORT-1:0]          port_ack,
    output logic [NPORT-1:0]          port_err,
    output logic [3:0]                port_fwd_port,
    output logic                      of_lookup_req,
    output logic [LOOKUP_W-1:0]       of_lookup_data,
    input  logic                      of_lookup_ack,
    input  logic                      of_lookup_err,
    input  logic [3:0]                of_lookup_fwd_port,
    output logic                      busy
);

    import lookupflow_pkg::*;

    localparam int             IDX_W    = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [7:0]     CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPORT - 1);

    state_t               state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic [NPORT-1:0]     gnt_oh_q;
    logic [NPORT-1:0]     holdoff_q;
    logic [NPORT-1:0]     ack_q;
    logic [NPORT-1:0]     err_q;
    logic [3:0]           fwd_q;
    logic                 req_q;
    logic [LOOKUP_W-1:0]  key_q;
    logic [7:0]           cnt_q;

    logic [LOOKUP_W-1:0]  port_key [NPORT];
    logic [NPORT-1:0]     arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;

    for (genvar i = 0; i < NPORT; i++) begin : g_key
        assign port_key[i] = port_data[i*LOOKUP_W +: LOOKUP_W];
    end

    // The port just answered is hidden for one IDLE cycle so it can drop req.
    rr_arbiter #(.N(NPORT), .IW(IDX_W)) u_rr (
        .req_i   (port_req & ~holdoff_q),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // NOTE: every register, the key included, is reset so all outputs read 0
    // during and straight after reset; non-blocking <= throughout, so each
    // branch sees the pre-edge value of every register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            gnt_oh_q  <= '0;
            holdoff_q <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            fwd_q     <= '0;
            req_q     <= 1'b0;
            key_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    holdoff_q <= '0;
                    if (arb_valid) begin
                        gnt_idx_q <= arb_idx;
                        gnt_oh_q  <= arb_grant;
                        key_q     <= port_key[arb_idx];
                        req_q     <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An ack here cannot belong to this request; it is ignored.
                    req_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (of_lookup_ack) begin
                        ack_q   <= gnt_oh_q;
                        err_q   <= of_lookup_err ? gnt_oh_q : '0;
                        fwd_q   <= of_lookup_fwd_port;
                        state_q <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        ack_q   <= gnt_oh_q;
                        err_q   <= gnt_oh_q;
                        fwd_q   <= '0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    ack_q     <= '0;
                    err_q     <= '0;
                    fwd_q     <= '0;
                    rr_ptr_q  <= (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IDX_W'(1);
                    holdoff_q <= gnt_oh_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign port_ack       = ack_q;
    assign port_err       = err_q;
    assign port_fwd_port  = fwd_q;
    assign of_lookup_req  = req_q;
    assign of_lookup_data = key_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_lookupflow_arbiter.sv
// Self-checking bench for lookupflow_arbiter: directed scenarios followed by
// randomized traffic, judged against a transaction-level reference model.
module tb_lookupflow_arbiter;

    import lookupflow_pkg::*;

    localparam int NP = 4;
    localparam int LW = LOOKUP_W;
    localparam int TO = 16;

    typedef logic [159:0] cval_t;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [NP-1:0]    port_req;
    logic [NP*LW-1:0] port_data;
    logic [NP-1:0]    port_ack;
    logic [NP-1:0]    port_err;
    logic [3:0]       port_fwd_port;
    logic             of_lookup_req;
    logic [LW-1:0]    of_lookup_data;
    logic             of_lookup_ack;
    logic             of_lookup_err;
    logic [3:0]       of_lookup_fwd_port;
    logic             busy;

    logic [LW-1:0]    keys [NP];
    int               ptr_m;
    logic [NP-1:0]    hold_m;
    int               n_pass = 0;
    int               n_fail = 0;
    int               n_total = 0;

    lookupflow_arbiter #(.NPORT(NP), .LOOKUP_W(LW), .TIMEOUT(TO)) dut (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .port_req           (port_req),
        .port_data          (port_data),
        .port_ack           (port_ack),
        .port_err           (port_err),
        .port_fwd_port      (port_fwd_port),
        .of_lookup_req      (of_lookup_req),
        .of_lookup_data     (of_lookup_data),
        .of_lookup_ack      (of_lookup_ack),
        .of_lookup_err      (of_lookup_err),
        .of_lookup_fwd_port (of_lookup_fwd_port),
        .busy               (busy)
    );

    always #5 sys_clk = ~sys_clk;

    for (genvar i = 0; i < NP; i++) begin : g_data
        assign port_data[i*LW +: LW] = keys[i];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input cval_t got, input cval_t exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NP-1:0] bit_of(input int i);
        return NP'(1) << i;
    endfunction

    // Reference rule: first requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [NP-1:0] cand, input int ptr);
        for (int k = 0; k < NP; k++)
            if (cand[(ptr + k) % NP]) return (ptr + k) % NP;
        return -1;
    endfunction

    function automatic logic [LW-1:0] rand_key(input int p);
        return make_key(4'(p), {16'($urandom), 32'($urandom)}, $urandom, $urandom);
    endfunction

    task automatic do_reset(input logic [NP-1:0] req_after);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("reset_outputs",
              cval_t'({busy, of_lookup_req, of_lookup_data, port_ack, port_err, port_fwd_port}),
              cval_t'(0));
        port_req      = req_after;
        of_lookup_ack = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        ptr_m     = 0;
        hold_m    = '0;
    endtask

    // One whole lookup, entered at a negedge with the DUT idle. ack_at is the
    // WAIT-cycle edge (2..TO+1) at which the engine acks, or 0 for never.
    task automatic txn(input int ack_at, input logic eerr, input logic [3:0] efwd,
                       input bit keep_req, input bit drop_early, input bit spurious,
                       output logic [NP-1:0] ack_seen);
        logic [NP-1:0] cand;
        logic          eff_err;
        int            g;
        int            r;
        cand   = port_req & ~hold_m;
        hold_m = '0;
        if (cand == '0) begin
            @(negedge sys_clk);
            check("holdoff_no_grant", cval_t'({busy, of_lookup_req}), cval_t'(0));
            cand = port_req;
        end
        g = rr_pick(cand, ptr_m);
        ack_seen = '0;
        if (g < 0) begin
            n_total++;
            n_fail++;
            $display("FAIL stimulus: no requester pending, observed=0 expected=nonzero");
            return;
        end
        r       = (ack_at == 0) ? TO + 1 : ack_at;
        eff_err = (ack_at == 0) ? 1'b1 : eerr;

        @(negedge sys_clk);
        check("issue_req", cval_t'({busy, of_lookup_req}), cval_t'(2'b11));
        check("issue_data", cval_t'(of_lookup_data), cval_t'(keys[g]));
        of_lookup_ack      = spurious;
        of_lookup_err      = 1'b1;
        of_lookup_fwd_port = 4'hF;
        if (drop_early) port_req[g] = 1'b0;

        for (int j = 1; j <= r; j++) begin
            @(negedge sys_clk);
            if (j < r)
                check("no_early_ack", cval_t'({busy, port_ack, of_lookup_req}), cval_t'({1'b1, NP'(0), 1'b0}));
            of_lookup_ack      = (j + 1 == ack_at);
            of_lookup_err      = eerr;
            of_lookup_fwd_port = efwd;
        end

        ack_seen = port_ack;
        check("resp_ack", cval_t'(port_ack), cval_t'(bit_of(g)));
        check("resp_err", cval_t'(port_err), cval_t'(eff_err ? bit_of(g) : NP'(0)));
        check("resp_fwd", cval_t'(port_fwd_port), cval_t'((ack_at == 0) ? 4'h0 : efwd));
        check("resp_busy_data", cval_t'({busy, of_lookup_data}), cval_t'({1'b1, keys[g]}));
        ptr_m  = (g + 1) % NP;
        hold_m = bit_of(g);
        if (!keep_req) port_req[g] = 1'b0;

        @(negedge sys_clk);
        check("idle_clear", cval_t'({busy, port_ack, port_err, port_fwd_port}), cval_t'(0));
    endtask

    initial begin
        logic [NP-1:0] seen;
        int            ack_at;
        int            sel;
        port_req           = '0;
        of_lookup_ack      = 1'b0;
        of_lookup_err      = 1'b0;
        of_lookup_fwd_port = '0;
        for (int i = 0; i < NP; i++) keys[i] = rand_key(i);

        // Reset, then a single request with the textbook latency.
        do_reset('0);
        keys[0]  = make_key(4'd0, 48'h0011_2233_4455, 32'h0A00_0002, 32'hC0A8_0001);
        port_req = 4'b0001;
        txn(2, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, seen);

        // Round robin with all four requesting; each drops and re-raises.
        do_reset(4'b1111);
        for (int i = 0; i < 5; i++) begin
            txn(2 + (i % 2), 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b0, seen);
            check("rr_order", cval_t'(seen), cval_t'(bit_of(i % NP)));
            port_req = 4'b1111;
        end

        // Hold-off: port 2 alone keeps req high across its ack.
        do_reset(4'b0100);
        txn(2, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, seen);
        txn(2, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, seen);
        check("holdoff_regrant", cval_t'(seen), cval_t'(4'b0100));

        // Timeout, and acks on the last two cycles before it.
        port_req = 4'b0010;
        txn(0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, seen);
        port_req = 4'b1000;
        txn(TO + 1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, seen);
        port_req = 4'b0001;
        txn(TO, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, seen);

        // Engine error with several requesters pending.
        port_req = 4'b1011;
        txn(3, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, seen);

        // Reset while WAIT: outputs clear at once, priority restarts at port 0.
        port_req = 4'b1111;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("busy_before_reset", cval_t'(busy), cval_t'(1'b1));
        do_reset(4'b1111);
        txn(2, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, seen);
        check("post_reset_grant", cval_t'(seen), cval_t'(4'b0001));

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < NP; p++) begin
                if (!port_req[p] && $urandom_range(0, 1) == 1) begin
                    keys[p]     = rand_key(p);
                    port_req[p] = 1'b1;
                end
            end
            if (port_req == '0) begin
                sel           = $urandom_range(0, NP - 1);
                keys[sel]     = rand_key(sel);
                port_req[sel] = 1'b1;
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      ack_at = 0;
            else if (sel == 1) ack_at = TO + 1;
            else if (sel == 2) ack_at = TO;
            else               ack_at = 2 + $urandom_range(0, 3);
            txn(ack_at, 1'($urandom), 4'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                (ack_at != 2) && ($urandom_range(0, 2) == 0), seen);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
